// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and counter sizing for the sequential ALU.
// The ALU_SEQ_DIV_EN build option is consumed by alu_seq and alu_seq_iter.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold an iteration count of 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath: shift-add multiply, plus restoring divide when
// ALU_SEQ_DIV_EN is defined. One iteration per cycle after start.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   result,
  output logic                 valid
);

  localparam int CW = cnt_width(WIDTH);

  // acc: partial product high half / partial remainder.
  // sh : multiplier bits being consumed / dividend becoming quotient.
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   add_sum;

`ifdef ALU_SEQ_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
`else
  logic             unused_mode;
  assign unused_mode = mode;
`endif

  assign add_sum = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);

  always_comb begin
    acc_nxt = add_sum[WIDTH:1];
    sh_nxt  = {add_sum[0], sh[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    shifted = {acc, sh[WIDTH-1]};
    trial   = shifted - {1'b0, opnd};
    if (div_q) begin
      // A borrow out of the trial subtraction means restore (keep shifted).
      if (!trial[WIDTH]) begin
        acc_nxt = trial[WIDTH-1:0];
        sh_nxt  = {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        sh_nxt  = {sh[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      sh   <= '0;
      opnd <= '0;
      cnt  <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      acc  <= '0;
      sh   <= mode ? A : B;
      opnd <= mode ? B : A;
      cnt  <= CW'(WIDTH);
`ifdef ALU_SEQ_DIV_EN
      div_q <= mode;
`endif
    end else if (cnt != '0) begin
      acc <= acc_nxt;
      sh  <= sh_nxt;
      cnt <= cnt - CW'(1);
    end
  end

  // The final iteration's outcome is presented combinationally so the
  // parent can register it on the same edge the counter reaches zero.
  assign result = {acc_nxt, sh_nxt};
  assign valid  = (cnt == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Registered sequential ALU: single-cycle ops plus iterative MUL (and DIV
// when ALU_SEQ_DIV_EN is defined) behind an init / busy / done handshake.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           sel,
  output logic [2*WIDTH-1:0]   Y,
  output logic                 zero,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state
);

  // Handshake: init is accepted only in IDLE; busy covers the iterative
  // cycles; done is a one-cycle pulse coincident with new Y/zero/overflow.
  state_t state, state_nxt;

  logic                 accept, is_iter, iter_start, iter_mode, iter_valid;
  logic [2*WIDTH-1:0]   iter_result, single_y;
  logic                 single_ovf, iter_ovf;
  logic [WIDTH:0]       sum, diff;

  assign accept = (state == IDLE) && init;
  assign sum    = {1'b0, A} + {1'b0, B};
  assign diff   = {1'b0, A} - {1'b0, B};

`ifdef ALU_SEQ_DIV_EN
  logic div_op_q, b_zero_q;
  assign is_iter   = (sel == OP_MUL) || (sel == OP_DIV);
  assign iter_mode = (sel == OP_DIV);
  assign iter_ovf  = div_op_q ? b_zero_q : (iter_result[2*WIDTH-1:WIDTH] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_op_q <= 1'b0;
      b_zero_q <= 1'b0;
    end else if (accept) begin
      div_op_q <= (sel == OP_DIV);
      b_zero_q <= (B == '0);
    end
  end
`else
  assign is_iter   = (sel == OP_MUL);
  assign iter_mode = 1'b0;
  assign iter_ovf  = (iter_result[2*WIDTH-1:WIDTH] != '0);
`endif

  assign iter_start = accept && is_iter;

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .mode   (iter_mode),
    .A      (A),
    .B      (B),
    .result (iter_result),
    .valid  (iter_valid)
  );

  always_comb begin
    single_y   = '0;
    single_ovf = 1'b0;
    case (sel)
      OP_ADD: begin
        single_y   = (2*WIDTH)'(sum);
        single_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        single_y   = (2*WIDTH)'(diff);
        single_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_OR:  single_y = (2*WIDTH)'(A | B);
      OP_AND: single_y = (2*WIDTH)'(A & B);
      OP_XOR: single_y = (2*WIDTH)'(A ^ B);
      OP_SHL: begin
        single_y   = (2*WIDTH)'({A, 1'b0});
        single_ovf = A[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init) state_nxt = is_iter ? RUN : DONE;
      RUN:     if (iter_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y        <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else if (accept && !is_iter) begin
      Y        <= single_y;
      zero     <= (single_y == '0);
      overflow <= single_ovf;
    end else if ((state == RUN) && iter_valid) begin
      Y        <= iter_result;
      zero     <= (iter_result == '0);
      overflow <= iter_ovf;
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule
